cam_read_register_table: RTL and testbench
==========================================

# cam_read_register_table

Readback side of the camera register table. Snoops the same register writes issued by the instruction buffer, keeps a shadow copy of the control, config, error and crop registers, and samples live status inputs. On a host read request it snapshots the addressed register and streams it out as 16-bit words, least-significant word first, over a valid/ready handshake toward the slave copy buffer.

## Interface
- No parameters.
- sysClk  in  1  system clock; all logic on the rising edge
- sysRst_n  in  1  synchronous, active-low reset
- wr_reg_addr  in  8  snooped write address from the instruction buffer
- wr_reg_data  in  128  snooped write data
- wr_valid  in  1  write strobe, one cycle per write
- rd_reg_addr  in  8  read address, sampled when rd_req is accepted
- rd_req  in  1  read request; accepted only when rd_busy=0
- st_proc_cam1, st_proc_cam2, st_erase_proc, st_booting  in  1 each  live status bits
- err_set  in  8  per-bit error set pulses
- rd_data  out  16  current output word
- rd_data_valid  out  1  rd_data is valid
- rd_data_ready  in  1  consumer accepts the word when valid and ready are both 1
- rd_last  out  1  current word is the last word of this register
- rd_busy  out  1  a read is in progress
- rd_addr_err  out  1  one-cycle pulse: the requested address is not defined

## Operation
- Register map:
  - 0x00 status: 1 word, {12'b0, booting, erase, cam2, cam1}.
  - 0x01 control: 1 word, data[15:0].
  - 0x02 and 0x03 config cam1 and cam2: 2 words each, data[31:0].
  - 0x04 error: 1 word, {8'b0, err[7:0]}.
  - 0x05 and 0x06 crop cam1 and cam2: 4 words each, data[63:0], in the order upper x, lower x, upper y, lower y.
- Write handling:
  - On wr_valid, addresses 0x01–0x03 and 0x05–0x06 load the low bits of wr_reg_data listed above.
  - A write to 0x04 with wr_reg_data[0]=1 clears err.
  - Writes to 0x00 and to undefined addresses are ignored.
- Error register: err <= (err & ~clr_mask) | err_set. A set wins over a clear in the same cycle.
- FSM states: IDLE and SEND.
- IDLE, rd_req=1, address defined:
  - The whole register (status sampled live at this point) is copied into a 64-bit snapshot.
  - Word count is loaded and the word index is set to 0.
  - Next state is SEND.
- IDLE, rd_req=1, address undefined: rd_addr_err pulses for one cycle and the FSM stays in IDLE.
- SEND:
  - rd_data = snapshot[16*idx +: 16].
  - On each handshake idx increments.
  - A handshake with rd_last=1 returns the FSM to IDLE.
- A write to the register being read, in the accept cycle or later, does not change the words already snapshotted.
- rd_req is ignored while rd_busy=1. No request queueing.

## Timing
- Reset values: rd_data=0, rd_data_valid=0, rd_last=0, rd_busy=0, rd_addr_err=0; all shadow registers and err are 0; FSM in IDLE.
- Latency: request accepted in cycle N; rd_data_valid=1 with word 0 in cycle N+1. rd_addr_err goes high in cycle N+1 for exactly one cycle.
- rd_busy goes high in cycle N+1 and stays high through the cycle of the final handshake. It returns to 0 in the following cycle.
- A new request can be accepted in that same cycle (rd_busy=0). Back-to-back words: one word per cycle while rd_data_ready=1.
- Holding rd_data_ready=0 holds rd_data, rd_data_valid and rd_last stable.
- rd_last=1 only while idx = count−1.
- Reset mid-read: on the next edge valid drops to 0, the FSM goes to IDLE and the shadow registers clear.

## Configuration
- CAM_RD_ERR_CLR_ON_READ_EN
  - Defined: the final handshake of a 0x04 read sets clr_mask to the snapshotted err bits for one cycle. Bits set during the read survive.
  - Not defined: err is cleared only by a 0x04 write with data[0]=1; reads are non-destructive.

## Test plan
- Write 0x05 with data[63:0]=0x0004_0003_0002_0001, then read 0x05 with ready held at 1 -> words 0x0001, 0x0002, 0x0003, 0x0004 on four consecutive cycles; rd_last only on 0x0004.
- Read 0x02 after writing 0xDEAD_BEEF; hold ready=0 for 3 cycles -> 0xBEEF held stable, then 0xDEAD with rd_last=1.
- Read 0x07 -> rd_addr_err high for one cycle, no rd_data_valid, rd_busy stays 0.
- Pulse err_set=0x05, read 0x04 -> word 0x0005. With the macro defined a second read returns 0x0000; without it the second read returns 0x0005.
- Write 0x01=0x1234, then read 0x01 while writing 0x01=0xABCD in the accept cycle -> 0x1234 returned; the next read returns 0xABCD.
- Set st_booting=1 and st_proc_cam2=1, then read 0x00 -> 0x000A. Assert sysRst_n=0 mid crop read -> valid=0 next cycle, and a following read of 0x05 returns all zero words.

Source files
------------

// File: rtl/cam_read_register_table.sv
// ============================================================================
//  Module   : cam_read_register_table
//  Purpose  : Readback side of the camera register table. Shadows the
//             control, config, error and crop registers by snooping the
//             instruction-buffer writes, samples live status bits, and on a
//             host read snapshots one register and streams it out as 16-bit
//             words (least-significant word first) over valid/ready.
//  Ports    : sysClk / sysRst_n        clock, synchronous active-low reset
//             wr_reg_addr/data/valid   snooped register writes
//             rd_reg_addr / rd_req     read request (accepted when idle)
//             st_* / err_set           live status bits, error set pulses
//             rd_data/_valid/_ready    output word stream handshake
//             rd_last / rd_busy        last word marker, read in progress
//             rd_addr_err              one-cycle pulse on undefined address
//  Option   : CAM_RD_ERR_CLR_ON_READ_EN - when defined, completing a read of
//             the error register clears the error bits that were returned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_read_register_table (
    input  logic         sysClk,
    input  logic         sysRst_n,
    input  logic [7:0]   wr_reg_addr,
    input  logic [127:0] wr_reg_data,
    input  logic         wr_valid,
    input  logic [7:0]   rd_reg_addr,
    input  logic         rd_req,
    input  logic         st_proc_cam1,
    input  logic         st_proc_cam2,
    input  logic         st_erase_proc,
    input  logic         st_booting,
    input  logic [7:0]   err_set,
    output logic [15:0]  rd_data,
    output logic         rd_data_valid,
    input  logic         rd_data_ready,
    output logic         rd_last,
    output logic         rd_busy,
    output logic         rd_addr_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Shadow registers
    logic [15:0] ctrl_q;
    logic [31:0] cfg1_q;
    logic [31:0] cfg2_q;
    logic [63:0] crop1_q;
    logic [63:0] crop2_q;
    logic [7:0]  err_q;
    logic [7:0]  err_d;
    logic [7:0]  clr_mask;

    // Read engine
    state_t      state_q;
    logic [63:0] snap_q;
    logic [2:0]  cnt_q;
    logic [1:0]  idx_q;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;
    logic        rd_last_q;
    logic        rd_busy_q;
    logic        rd_addr_err_q;
`ifdef CAM_RD_ERR_CLR_ON_READ_EN
    logic        rd_is_err_q;
`endif

    logic [63:0] sel_data;
    logic [2:0]  sel_cnt;
    logic        handshake;
    logic [1:0]  nxt_idx;
    logic        unused_wr_upper;

    // Only the low 64 bits of a write ever land in a shadow register.
    assign unused_wr_upper = ^wr_reg_data[127:64];

    assign handshake = rd_valid_q && rd_data_ready;
    assign nxt_idx   = idx_q + 2'd1;

    // Register mux; a zero word count marks an undefined address.
    always_comb begin
        sel_data = 64'd0;
        sel_cnt  = 3'd0;
        case (rd_reg_addr)
            8'h00: begin
                sel_data = {60'd0, st_booting, st_erase_proc, st_proc_cam2, st_proc_cam1};
                sel_cnt  = 3'd1;
            end
            8'h01: begin sel_data = {48'd0, ctrl_q};        sel_cnt = 3'd1; end
            8'h02: begin sel_data = {32'd0, cfg1_q};        sel_cnt = 3'd2; end
            8'h03: begin sel_data = {32'd0, cfg2_q};        sel_cnt = 3'd2; end
            8'h04: begin sel_data = {48'd0, 8'd0, err_q};   sel_cnt = 3'd1; end
            8'h05: begin sel_data = crop1_q;                sel_cnt = 3'd4; end
            8'h06: begin sel_data = crop2_q;                sel_cnt = 3'd4; end
            default: begin sel_data = 64'd0;                sel_cnt = 3'd0; end
        endcase
    end

    // Error register: a set pulse always wins over a clear in the same cycle.
    always_comb begin
        clr_mask = 8'h00;
        if (wr_valid && (wr_reg_addr == 8'h04) && wr_reg_data[0]) begin
            clr_mask = 8'hFF;
        end
`ifdef CAM_RD_ERR_CLR_ON_READ_EN
        // Clear only the bits the host actually saw; new sets survive.
        if (handshake && rd_last_q && rd_is_err_q) begin
            clr_mask = clr_mask | snap_q[7:0];
        end
`endif
        err_d = (err_q & ~clr_mask) | err_set;
    end

    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            ctrl_q  <= 16'd0;
            cfg1_q  <= 32'd0;
            cfg2_q  <= 32'd0;
            crop1_q <= 64'd0;
            crop2_q <= 64'd0;
            err_q   <= 8'd0;
        end else begin
            if (wr_valid) begin
                case (wr_reg_addr)
                    8'h01:   ctrl_q  <= wr_reg_data[15:0];
                    8'h02:   cfg1_q  <= wr_reg_data[31:0];
                    8'h03:   cfg2_q  <= wr_reg_data[31:0];
                    8'h05:   crop1_q <= wr_reg_data[63:0];
                    8'h06:   crop2_q <= wr_reg_data[63:0];
                    default: ;
                endcase
            end
            err_q <= err_d;
        end
    end

    // Read FSM. The snapshot is taken from the pre-write shadow values, so a
    // write in the accept cycle never alters the words being streamed.
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            state_q       <= S_IDLE;
            snap_q        <= 64'd0;
            cnt_q         <= 3'd0;
            idx_q         <= 2'd0;
            rd_data_q     <= 16'd0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_busy_q     <= 1'b0;
            rd_addr_err_q <= 1'b0;
`ifdef CAM_RD_ERR_CLR_ON_READ_EN
            rd_is_err_q   <= 1'b0;
`endif
        end else begin
            rd_addr_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        if (sel_cnt != 3'd0) begin
                            snap_q     <= sel_data;
                            cnt_q      <= sel_cnt;
                            idx_q      <= 2'd0;
                            rd_data_q  <= sel_data[15:0];
                            rd_valid_q <= 1'b1;
                            rd_busy_q  <= 1'b1;
                            rd_last_q  <= (sel_cnt == 3'd1);
`ifdef CAM_RD_ERR_CLR_ON_READ_EN
                            rd_is_err_q <= (rd_reg_addr == 8'h04);
`endif
                            state_q    <= S_SEND;
                        end else begin
                            rd_addr_err_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (rd_last_q) begin
                            rd_data_q  <= 16'd0;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            rd_busy_q  <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q     <= nxt_idx;
                            rd_data_q <= snap_q[{nxt_idx, 4'b0000} +: 16];
                            rd_last_q <= ({1'b0, nxt_idx} == (cnt_q - 3'd1));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign rd_busy       = rd_busy_q;
    assign rd_addr_err   = rd_addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_read_register_table.sv
// ============================================================================
//  Module   : tb_cam_read_register_table
//  Purpose  : Scoreboard bench for cam_read_register_table. Directed reads
//             push expected words; a negedge monitor pops and compares on
//             every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_read_register_table;

    logic         sysClk = 1'b0;
    logic         sysRst_n;
    logic [7:0]   wr_reg_addr;
    logic [127:0] wr_reg_data;
    logic         wr_valid;
    logic [7:0]   rd_reg_addr;
    logic         rd_req;
    logic         st_proc_cam1, st_proc_cam2, st_erase_proc, st_booting;
    logic [7:0]   err_set;
    logic [15:0]  rd_data;
    logic         rd_data_valid;
    logic         rd_data_ready;
    logic         rd_last;
    logic         rd_busy;
    logic         rd_addr_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          n_cyc;

    always #5 sysClk = ~sysClk;

    cam_read_register_table dut (
        .sysClk        (sysClk),
        .sysRst_n      (sysRst_n),
        .wr_reg_addr   (wr_reg_addr),
        .wr_reg_data   (wr_reg_data),
        .wr_valid      (wr_valid),
        .rd_reg_addr   (rd_reg_addr),
        .rd_req        (rd_req),
        .st_proc_cam1  (st_proc_cam1),
        .st_proc_cam2  (st_proc_cam2),
        .st_erase_proc (st_erase_proc),
        .st_booting    (st_booting),
        .err_set       (err_set),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_last       (rd_last),
        .rd_busy       (rd_busy),
        .rd_addr_err   (rd_addr_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge sysClk) begin
        if (sysRst_n === 1'b1 && rd_data_valid === 1'b1 && rd_data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got 0x%0h last=%0b, expected none", rd_data, rd_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("word{last,data}", {47'd0, rd_last, rd_data}, {47'd0, mon_e});
            end
        end
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic do_write(input logic [7:0] a, input logic [63:0] d);
        wr_reg_addr = a;
        wr_reg_data = {64'd0, d};
        wr_valid    = 1'b1;
        tick();
        wr_valid    = 1'b0;
    endtask

    task automatic read_req(input logic [7:0] a);
        rd_reg_addr = a;
        rd_req      = 1'b1;
        tick();
        rd_req      = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (rd_busy === 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected idle", n);
        end
    endtask

    initial begin
        sysRst_n = 1'b0;
        wr_reg_addr = 8'd0; wr_reg_data = 128'd0; wr_valid = 1'b0;
        rd_reg_addr = 8'd0; rd_req = 1'b0;
        st_proc_cam1 = 1'b0; st_proc_cam2 = 1'b0; st_erase_proc = 1'b0; st_booting = 1'b0;
        err_set = 8'd0;
        rd_data_ready = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("rst_data",  {48'd0, rd_data}, 64'd0);
        check("rst_valid", {63'd0, rd_data_valid}, 64'd0);
        check("rst_last",  {63'd0, rd_last}, 64'd0);
        check("rst_busy",  {63'd0, rd_busy}, 64'd0);
        check("rst_aerr",  {63'd0, rd_addr_err}, 64'd0);
        sysRst_n = 1'b1;
        tick();

        // Crop cam1: four words back to back
        do_write(8'h05, 64'h0004_0003_0002_0001);
        push(16'h0001, 1'b0); push(16'h0002, 1'b0); push(16'h0003, 1'b0); push(16'h0004, 1'b1);
        read_req(8'h05);
        check("crop_first_valid", {63'd0, rd_data_valid}, 64'd1);
        check("crop_busy", {63'd0, rd_busy}, 64'd1);
        wait_idle(n_cyc);
        check("crop_cycles", n_cyc, 64'd4);

        // Config cam1 with backpressure
        do_write(8'h02, 64'h0000_0000_DEAD_BEEF);
        rd_data_ready = 1'b0;
        push(16'hBEEF, 1'b0); push(16'hDEAD, 1'b1);
        read_req(8'h02);
        check("cfg_w0", {48'd0, rd_data}, 64'h0000_0000_0000_BEEF);
        tick(); tick(); tick();
        check("cfg_hold_data", {48'd0, rd_data}, 64'h0000_0000_0000_BEEF);
        check("cfg_hold_valid", {63'd0, rd_data_valid}, 64'd1);
        check("cfg_hold_last", {63'd0, rd_last}, 64'd0);
        rd_data_ready = 1'b1;
        wait_idle(n_cyc);

        // Undefined address
        read_req(8'h07);
        check("aerr_pulse", {63'd0, rd_addr_err}, 64'd1);
        check("aerr_valid", {63'd0, rd_data_valid}, 64'd0);
        check("aerr_busy", {63'd0, rd_busy}, 64'd0);
        tick();
        check("aerr_one_cycle", {63'd0, rd_addr_err}, 64'd0);

        // Error register
        err_set = 8'h05;
        tick();
        err_set = 8'h00;
        push(16'h0005, 1'b1);
        read_req(8'h04);
        wait_idle(n_cyc);
`ifdef CAM_RD_ERR_CLR_ON_READ_EN
        push(16'h0000, 1'b1);
`else
        push(16'h0005, 1'b1);
`endif
        read_req(8'h04);
        wait_idle(n_cyc);
        do_write(8'h04, 64'd1);
        push(16'h0000, 1'b1);
        read_req(8'h04);
        wait_idle(n_cyc);

        // Write in the accept cycle does not disturb the snapshot
        do_write(8'h01, 64'h1234);
        push(16'h1234, 1'b1);
        rd_reg_addr = 8'h01; rd_req = 1'b1;
        wr_reg_addr = 8'h01; wr_reg_data = 128'hABCD; wr_valid = 1'b1;
        tick();
        rd_req = 1'b0; wr_valid = 1'b0;
        wait_idle(n_cyc);
        push(16'hABCD, 1'b1);
        read_req(8'h01);
        wait_idle(n_cyc);

        // Live status
        st_booting = 1'b1; st_proc_cam2 = 1'b1;
        push(16'h000A, 1'b1);
        read_req(8'h00);
        wait_idle(n_cyc);
        st_booting = 1'b0; st_proc_cam2 = 1'b0;

        // Reset in the middle of a crop read
        do_write(8'h05, 64'h1111_2222_3333_4444);
        rd_data_ready = 1'b0;
        read_req(8'h05);
        check("midrst_valid_before", {63'd0, rd_data_valid}, 64'd1);
        sysRst_n = 1'b0;
        tick();
        check("midrst_valid", {63'd0, rd_data_valid}, 64'd0);
        check("midrst_busy", {63'd0, rd_busy}, 64'd0);
        sysRst_n = 1'b1;
        rd_data_ready = 1'b1;
        push(16'h0000, 1'b0); push(16'h0000, 1'b0); push(16'h0000, 1'b0); push(16'h0000, 1'b1);
        read_req(8'h05);
        wait_idle(n_cyc);
        push(16'h0000, 1'b1);
        read_req(8'h01);
        wait_idle(n_cyc);

        tick();
        check("scoreboard_drained", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
